// File: rtl/eth_pkg.sv
// eth_pkg: constants, FSM state type and the bytewise CRC-32 step shared by
// the Ethernet transmit framer and its CRC engine.
//   PREAMBLE_BYTE / SFD_BYTE : frame start delimiters
//   CRC_POLY / CRC_INIT      : reflected CRC-32 polynomial and seed
//   tx_state_t               : framer states
//   crc32_byte()             : advance a reflected CRC-32 by one byte, LSB first
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    PAYLOAD,
    PAD,
    FCS,
    IFG
  } tx_state_t;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                             input logic [7:0]  d);
    logic [31:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ d[i];
      c  = {1'b0, c[31:1]} ^ (fb ? CRC_POLY : 32'h0000_0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: byte-wide reflected CRC-32 register.
//   clk  : clock
//   rst  : synchronous active-high reset, loads CRC_INIT
//   init : synchronous reload of CRC_INIT (takes priority over en)
//   en   : fold d into the CRC this cycle
//   d    : data byte, consumed LSB first
//   crc  : current (uninverted) CRC value
module crc32_d8
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  d,
  output logic [31:0] crc
);

  logic [31:0] crc_next;

  always_comb begin
    crc_next = crc32_byte(crc, d);
  end

  always_ff @(posedge clk) begin
    if (rst || init) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc_next;
    end
  end

endmodule

// File: rtl/eth_tx_framer.sv
// eth_tx_framer: drains the TX byte FIFO onto a GMII-style 8-bit transmit
// interface, adding preamble/SFD, zero padding up to MIN_LEN, the CRC-32 FCS
// and the inter-frame gap.
//   clk, rst               : clock, synchronous active-high reset
//   frame_valid/frame_len  : frame descriptor (length in FIFO bytes)
//   frame_ready            : descriptor accepted only while idle
//   fifo_dout/fifo_empty   : FIFO read data (one cycle after the strobe), empty
//   fifo_rd_en             : FIFO read strobe (combinational)
//   txd/tx_en/tx_er        : registered transmit byte, enable, error
//   len_err                : pulse, descriptor length rejected
//   underrun               : pulse, frame aborted because the FIFO ran dry
//
// The state names what is being loaded into txd at the coming edge, so the
// two-cycle FIFO read-to-txd path lines up: the read issued in SFD lands on
// txd right after the SFD byte.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | waiting for a descriptor; acceptance loads the first 0x55
//   PREAMBLE | loading the remaining six 0x55 bytes
//   SFD      | loading 0xD5; first FIFO read issued
//   PAYLOAD  | loading the byte read last cycle; prefetching the next one;
//            | a missing read turns into the tx_er abort cycle
//   PAD      | loading 0x00 until MIN_LEN bytes have been sent
//   FCS      | loading ~crc, least-significant byte first
//   IFG      | idle gap, tx_en low, then back to IDLE
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter int MIN_LEN    = 60,
  parameter int MAX_LEN    = 1514,
  parameter int IFG_CYCLES = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_valid,
  input  logic [10:0] frame_len,
  output logic        frame_ready,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [7:0]  txd,
  output logic        tx_en,
  output logic        tx_er,
  output logic        len_err,
  output logic        underrun
);

  localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
  localparam logic [10:0] IFG_L   = 11'(IFG_CYCLES);
  // Acceptance loads the first preamble byte, PREAMBLE loads the other six.
  localparam logic [10:0] PRE_CNT = 11'd5;
  localparam logic [10:0] FCS_CNT = 11'd3;

  tx_state_t   state;
  logic [10:0] len_q;
  logic [10:0] cnt;      // shared down-counter, terminal count at zero
  logic [10:0] rd_left;  // FIFO reads still owed for this frame
  logic        rd_q;     // a read was issued last cycle, fifo_dout is valid

  logic        crc_init;
  logic        crc_en;
  logic [7:0]  crc_d;
  logic [31:0] crc;
  logic [31:0] fcs;
  logic [7:0]  fcs_byte;

  assign frame_ready = (state == IDLE);

  // Once a read is missed in PAYLOAD (rd_q low), no further reads are issued
  // so the rest of the frame stays in the FIFO.
  assign fifo_rd_en = !rst && (rd_left != 11'd0) && !fifo_empty &&
                      ((state == SFD) || ((state == PAYLOAD) && rd_q));

  assign crc_init = (state == IDLE);
  assign crc_en   = ((state == PAYLOAD) && rd_q) || (state == PAD);
  assign crc_d    = (state == PAD) ? 8'h00 : fifo_dout;

  crc32_d8 u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (crc_init),
    .en   (crc_en),
    .d    (crc_d),
    .crc  (crc)
  );

  assign fcs = ~crc;

  // cnt runs 3..0 in FCS, which selects bytes 0..3 of the inverted CRC.
  always_comb begin
    fcs_byte = fcs[31:24];
    case (cnt[1:0])
      2'd3:    fcs_byte = fcs[7:0];
      2'd2:    fcs_byte = fcs[15:8];
      2'd1:    fcs_byte = fcs[23:16];
      default: fcs_byte = fcs[31:24];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      txd      <= 8'h00;
      tx_en    <= 1'b0;
      tx_er    <= 1'b0;
      len_err  <= 1'b0;
      underrun <= 1'b0;
      len_q    <= 11'd0;
      cnt      <= 11'd0;
      rd_left  <= 11'd0;
      rd_q     <= 1'b0;
    end else begin
      len_err  <= 1'b0;
      underrun <= 1'b0;
      tx_er    <= 1'b0;
      rd_q     <= fifo_rd_en;
      if (fifo_rd_en) begin
        rd_left <= rd_left - 11'd1;
      end

      case (state)
        IDLE: begin
          txd   <= 8'h00;
          tx_en <= 1'b0;
          if (frame_valid) begin
            if ((frame_len == 11'd0) || (frame_len > MAX_L)) begin
              len_err <= 1'b1;
            end else begin
              len_q   <= frame_len;
              rd_left <= frame_len;
              cnt     <= PRE_CNT;
              txd     <= PREAMBLE_BYTE;
              tx_en   <= 1'b1;
              state   <= PREAMBLE;
            end
          end
        end

        PREAMBLE: begin
          txd   <= PREAMBLE_BYTE;
          tx_en <= 1'b1;
          if (cnt == 11'd0) begin
            state <= SFD;
          end else begin
            cnt <= cnt - 11'd1;
          end
        end

        SFD: begin
          txd   <= SFD_BYTE;
          tx_en <= 1'b1;
          cnt   <= len_q;
          state <= PAYLOAD;
        end

        PAYLOAD: begin
          tx_en <= 1'b1;
          if (rd_q) begin
            txd <= fifo_dout;
            cnt <= cnt - 11'd1;
            if (cnt == 11'd1) begin
              if (len_q < MIN_L) begin
                cnt   <= MIN_L - len_q - 11'd1;
                state <= PAD;
              end else begin
                cnt   <= FCS_CNT;
                state <= FCS;
              end
            end
          end else begin
            // FIFO ran dry: one error byte, no FCS, straight into the gap.
            txd      <= 8'h00;
            tx_er    <= 1'b1;
            underrun <= 1'b1;
            rd_left  <= 11'd0;
            cnt      <= IFG_L;
            state    <= IFG;
          end
        end

        PAD: begin
          txd   <= 8'h00;
          tx_en <= 1'b1;
          if (cnt == 11'd0) begin
            cnt   <= FCS_CNT;
            state <= FCS;
          end else begin
            cnt <= cnt - 11'd1;
          end
        end

        FCS: begin
          txd   <= fcs_byte;
          tx_en <= 1'b1;
          if (cnt == 11'd0) begin
            // IFG_CYCLES+1 state cycles: the first still shows the last FCS
            // byte, the remaining IFG_CYCLES are idle on the wire.
            cnt   <= IFG_L;
            state <= IFG;
          end else begin
            cnt <= cnt - 11'd1;
          end
        end

        IFG: begin
          txd   <= 8'h00;
          tx_en <= 1'b0;
          if (cnt == 11'd0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 11'd1;
          end
        end

        default: begin
          txd   <= 8'h00;
          tx_en <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Testbench for eth_tx_framer: directed frames with a FIFO model, a transmit
// byte scoreboard and a standalone check of the CRC engine.
module tb_eth_tx_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_valid = 1'b0;
  logic [10:0] frame_len = 11'd0;
  logic        frame_ready;
  logic [7:0]  fifo_dout = 8'h00;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  txd;
  logic        tx_en;
  logic        tx_er;
  logic        len_err;
  logic        underrun;

  logic        c_init = 1'b0;
  logic        c_en = 1'b0;
  logic [7:0]  c_d = 8'h00;
  logic [31:0] c_crc;

  always #5 clk = ~clk;

  eth_tx_framer #(.MIN_LEN(60), .MAX_LEN(1514), .IFG_CYCLES(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_valid (frame_valid),
    .frame_len   (frame_len),
    .frame_ready (frame_ready),
    .fifo_dout   (fifo_dout),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .txd         (txd),
    .tx_en       (tx_en),
    .tx_er       (tx_er),
    .len_err     (len_err),
    .underrun    (underrun)
  );

  crc32_d8 u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (c_init),
    .en   (c_en),
    .d    (c_d),
    .crc  (c_crc)
  );

  // FIFO model: main process writes, this process reads.
  logic [7:0] mem [0:255];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic [7:0] pay [0:255];

  assign fifo_empty = (rd_ptr == wr_ptr);

  initial forever begin
    @(posedge clk);
    if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_dout <= mem[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Scoreboard and check queues, consumed by the monitor.
  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  logic [8:0] exp_q [$];
  chk_t       chk_q [$];
  int n_vec = 0, n_err = 0;
  int n_txen = 0, n_rd = 0, n_lenerr = 0, n_under = 0, gap = 0, sb_idx = 0;
  logic [8:0] mon_e;
  chk_t       mon_c;

  initial forever begin
    @(negedge clk);
    if (fifo_rd_en) n_rd++;
    if (len_err) n_lenerr++;
    if (underrun) n_under++;
    if (tx_en) begin
      n_txen++;
      gap = 0;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_extra byte %0d: got er=%0b txd=%02h, required no transmit",
                 sb_idx, tx_er, txd);
      end else begin
        mon_e = exp_q.pop_front();
        if ({tx_er, txd} !== mon_e) begin
          n_err++;
          $display("FAIL sb_byte %0d: got er=%0b txd=%02h, required er=%0b txd=%02h",
                   sb_idx, tx_er, txd, mon_e[8], mon_e[7:0]);
        end
      end
      sb_idx++;
    end else if (!frame_ready) begin
      gap++;
    end
    while (chk_q.size() > 0) begin
      mon_c = chk_q.pop_front();
      n_vec++;
      if (mon_c.act !== mon_c.exp) begin
        n_err++;
        $display("FAIL %s: got %0h, required %0h", mon_c.name, mon_c.act, mon_c.exp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_fifo(input int n, input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < n; i++) begin
      pay[i] = base + 8'(i) * step;
      mem[wr_ptr[7:0]] = pay[i];
      wr_ptr++;
    end
  endtask

  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  task automatic expect_frame(input int len, input int avail);
    logic [31:0] crc;
    int          n;
    for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
    crc = 32'hFFFFFFFF;
    n = (avail < len) ? avail : len;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b0, pay[i]});
      crc = ref_crc(crc, pay[i]);
    end
    if (avail < len) begin
      exp_q.push_back({1'b1, 8'h00});
      return;
    end
    for (int i = len; i < 60; i++) begin
      exp_q.push_back({1'b0, 8'h00});
      crc = ref_crc(crc, 8'h00);
    end
    crc = ~crc;
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, crc[8*i +: 8]});
  endtask

  task automatic send(input int len);
    frame_valid = 1'b1;
    frame_len   = 11'(len);
    tick();
    frame_valid = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int c;
    c = 0;
    while (!frame_ready && c < 400) begin
      tick();
      c++;
    end
    chk(name, 32'(frame_ready), 1);
  endtask

  task automatic run_frame(input string tag, input int len, input int avail,
                           input int txen_exp, input int rd_exp, input int under_exp);
    int t0, r0, u0;
    expect_frame(len, avail);
    t0 = n_txen;
    r0 = n_rd;
    u0 = n_under;
    send(len);
    wait_ready({tag, "_ready"});
    chk({tag, "_ifg"}, gap, 12);
    chk({tag, "_txen"}, n_txen - t0, txen_exp);
    chk({tag, "_rd"}, n_rd - r0, rd_exp);
    chk({tag, "_under"}, n_under - u0, under_exp);
    chk({tag, "_sb_left"}, exp_q.size(), 0);
  endtask

  task automatic bad_len(input string tag, input int len);
    int t0, r0, l0;
    t0 = n_txen;
    r0 = n_rd;
    l0 = n_lenerr;
    send(len);
    chk({tag, "_pulse"}, 32'(len_err), 1);
    chk({tag, "_ready"}, 32'(frame_ready), 1);
    repeat (20) tick();
    chk({tag, "_pulses"}, n_lenerr - l0, 1);
    chk({tag, "_txen"}, n_txen - t0, 0);
    chk({tag, "_rd"}, n_rd - r0, 0);
    chk({tag, "_ready_after"}, 32'(frame_ready), 1);
  endtask

  int m_t0;

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_outputs", 32'({txd, tx_en, tx_er, len_err, underrun}), 0);
    chk("rst_ready", 32'(frame_ready), 1);
    rst = 1'b0;
    tick();
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_ready_after", 32'(frame_ready), 1);

    // CRC engine on "123456789"
    c_init = 1'b1;
    tick();
    c_init = 1'b0;
    chk("crc_init", c_crc, 32'hFFFFFFFF);
    for (int i = 0; i < 9; i++) begin
      c_en = 1'b1;
      c_d  = 8'h31 + 8'(i);
      tick();
    end
    c_en = 1'b0;
    chk("crc_check", c_crc, 32'h340BC6D9);
    chk("crc_fcs", ~c_crc, 32'hCBF43926);

    load_fifo(64, 8'h00, 8'd1);
    run_frame("f64", 64, 64, 76, 64, 0);

    load_fifo(14, 8'hA0, 8'd3);
    run_frame("f14", 14, 14, 72, 14, 0);

    load_fifo(59, 8'h11, 8'd7);
    run_frame("f59", 59, 59, 72, 59, 0);

    bad_len("len0", 0);
    bad_len("len1515", 1515);

    load_fifo(40, 8'hC0, 8'd1);
    run_frame("urun", 100, 40, 49, 40, 1);

    // Reset while in PAYLOAD: 7 preamble, SFD and 4 payload bytes go out.
    load_fifo(20, 8'h5A, 8'd5);
    for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, pay[i]});
    m_t0 = n_txen;
    send(20);
    repeat (11) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_outputs", 32'({txd, tx_en, tx_er, len_err, underrun}), 0);
    chk("mid_rst_ready", 32'(frame_ready), 1);
    rst = 1'b0;
    tick();
    chk("mid_rst_ready_after", 32'(frame_ready), 1);
    chk("mid_rst_rd_en", 32'(fifo_rd_en), 0);
    chk("mid_rst_tx_en", 32'(tx_en), 0);
    repeat (5) tick();
    chk("mid_rst_txen", n_txen - m_t0, 12);
    chk("mid_rst_sb_left", exp_q.size(), 0);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
